// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the single-cycle MIPS core data port.
//               Inserts WAIT wait states, answers with a one-cycle ready pulse,
//               rejects illegal accesses with err, and counts committed writes.
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous active-low reset
//               memwrite   - write request, held until ready
//               memread    - read request, held until ready
//               dataadr    - byte address, held until ready
//               writedata  - write data, held until ready
//               readdata   - read result, valid with ready, then holds
//               ready      - one-cycle completion pulse
//               err        - qualifies ready, 1 = access rejected
//               wr_count   - committed write count, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic             memread,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             ready,
  output logic             err,
  output logic [CNT_W-1:0] wr_count
);

  localparam int              c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_CW        = $clog2(WAIT + 2);
  localparam logic [29:0]     c_DEPTH_W   = 30'(DEPTH);
  // The counter holds the number of edges left before the ready cycle.
  // A legal access needs WAIT+1 edges after the sampling edge, a rejected
  // access only one.
  localparam logic [c_CW-1:0] c_LEGAL_CNT = c_CW'(WAIT + 1);
  localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_CW-1:0]  r_cnt;
  logic [c_CW-1:0]  w_cnt_nxt;

  logic             r_wr;
  logic             r_bad;
  logic [c_AW-1:0]  r_idx;
  logic [31:0]      r_wdata;

  logic             r_ready;
  logic             r_err;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_wr_count;
  logic [31:0]      r_mem [DEPTH];

  logic             w_req;
  logic             w_illegal;
  logic             w_latch;
  logic             w_complete;
  logic             w_ready_nxt;
  logic             w_err_nxt;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_req     = memwrite | memread;
  assign w_illegal = (memwrite & memread)
                   | (dataadr[1:0] != 2'b00)
                   | (dataadr[31:2] >= c_DEPTH_W);

  // Reset gates the commit so an access in flight is never performed.
  assign w_do_wr = w_complete & reset & r_wr & ~r_bad;
  assign w_do_rd = w_complete & reset & ~r_wr & ~r_bad;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and registered-output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_complete  = 1'b0;
    w_ready_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_latch     = 1'b1;
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = w_illegal ? c_ONE : c_LEGAL_CNT;
        end
      end
      S_BUSY: begin
        if (r_cnt == c_ONE) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
          w_complete  = 1'b1;
          w_ready_nxt = 1'b1;
          w_err_nxt   = r_bad;
        end else begin
          w_cnt_nxt   = r_cnt - c_ONE;
        end
      end
      // The ready cycle: inputs are ignored so a request the core still
      // holds here is not mistaken for a new one.
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture; inputs are ignored after the sampling edge
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_wr    <= memwrite;
      r_bad   <= w_illegal;
      r_idx   <= dataadr[c_AW+1:2];
      r_wdata <= writedata;
    end
  end

  // --------------------------------------------------------------------------
  // Storage array, deliberately not cleared by reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_wr_count <= '0;
    end else begin
      r_ready <= w_ready_nxt;
      r_err   <= w_err_nxt;
      if (w_do_rd) begin
        r_rdata <= r_mem[r_idx];
      end
      if (w_do_wr && (r_wr_count != {CNT_W{1'b1}})) begin
        r_wr_count <= r_wr_count + CNT_W'(1);
      end
    end
  end

  assign readdata = r_rdata;
  assign ready    = r_ready;
  assign err      = r_err;
  assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. Instance A uses two
//               wait states and a 16-bit counter, instance B zero wait states
//               and a 2-bit counter. Expected values come from a word-array
//               model of the memory, a saturating count and the last read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH  = 64;
  localparam int WAIT_A = 2;
  localparam int WAIT_B = 0;
  localparam int CNTW_A = 16;
  localparam int CNTW_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, rst_b;
  logic              a_memwrite, a_memread, b_memwrite, b_memread;
  logic [31:0]       a_dataadr, a_writedata, b_dataadr, b_writedata;
  logic [31:0]       a_readdata, b_readdata;
  logic              a_ready, a_err, b_ready, b_err;
  logic [CNTW_A-1:0] a_wr_count;
  logic [CNTW_B-1:0] b_wr_count;

  dmem_responder #(.DEPTH(DEPTH), .WAIT(WAIT_A), .CNT_W(CNTW_A)) u_dut_a (
    .clk       (clk),
    .reset     (rst_a),
    .memwrite  (a_memwrite),
    .memread   (a_memread),
    .dataadr   (a_dataadr),
    .writedata (a_writedata),
    .readdata  (a_readdata),
    .ready     (a_ready),
    .err       (a_err),
    .wr_count  (a_wr_count)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT(WAIT_B), .CNT_W(CNTW_B)) u_dut_b (
    .clk       (clk),
    .reset     (rst_b),
    .memwrite  (b_memwrite),
    .memread   (b_memread),
    .dataadr   (b_dataadr),
    .writedata (b_writedata),
    .readdata  (b_readdata),
    .ready     (b_ready),
    .err       (b_err),
    .wr_count  (b_wr_count)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [2][DEPTH];
  int          cnt_m [2];
  int          cmax_m[2];
  logic [31:0] rd_m  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic wr, input logic rd,
                       input logic [31:0] adr, input logic [31:0] wd);
    if (sel == 0) begin
      a_memwrite = wr; a_memread = rd; a_dataadr = adr; a_writedata = wd;
    end else begin
      b_memwrite = wr; b_memread = rd; b_dataadr = adr; b_writedata = wd;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? a_ready : b_ready;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? a_err : b_err;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? a_readdata : b_readdata;
  endfunction
  function automatic logic [31:0] get_cnt(input int sel);
    return (sel == 0) ? 32'(a_wr_count) : 32'(b_wr_count);
  endfunction

  // One complete access. Ready must first appear exactly lat edges after the
  // sampling edge; err must stay low until then. With hold=1 the request is
  // left asserted on return.
  task automatic xact(input int sel, input logic wr, input logic rd,
                      input logic [31:0] adr, input logic [31:0] wd, input bit hold);
    bit bad;
    int lat;
    int k;
    bit seen;
    bad = (wr && rd) || (adr[1:0] != 2'b00) || ((adr >> 2) >= 32'(DEPTH));
    lat = bad ? 1 : (((sel == 0) ? WAIT_A : WAIT_B) + 1);
    @(negedge clk);
    drive(sel, wr, rd, adr, wd);
    @(posedge clk); #1;
    k    = 0;
    seen = 0;
    while (!seen && k < 40) begin
      if (get_ready(sel)) begin
        seen = 1;
      end else begin
        chk("err_without_ready", 32'(get_err(sel)), 32'd0);
        @(posedge clk); #1;
        k++;
      end
    end
    chk("ready_seen", 32'(seen), 32'd1);
    chk("latency", 32'(k), 32'(lat));
    if (!bad) begin
      if (wr) begin
        mem_m[sel][adr >> 2] = wd;
        if (cnt_m[sel] < cmax_m[sel]) cnt_m[sel]++;
      end else begin
        rd_m[sel] = mem_m[sel][adr >> 2];
      end
    end
    if (seen) begin
      chk("err", 32'(get_err(sel)), 32'(bad));
      chk("readdata", get_rdata(sel), rd_m[sel]);
      chk("wr_count", get_cnt(sel), 32'(cnt_m[sel]));
    end
    if (!hold) drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk("ready_pulse", 32'(get_ready(sel)), 32'd0);
  endtask

  task automatic preload(input int sel);
    for (int i = 0; i < DEPTH; i++) begin
      xact(sel, 1'b1, 1'b0, 32'(i) << 2, $urandom, 1'b0);
    end
  endtask

  task automatic random_run(input int sel, input int n);
    int          kind;
    logic [31:0] adr;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      kind = $urandom_range(0, 9);
      adr  = 32'($urandom_range(0, DEPTH - 1)) << 2;
      case (kind)
        0, 1, 2, 3: xact(sel, 1'b1, 1'b0, adr, $urandom, 1'b0);
        4, 5, 6:    xact(sel, 1'b0, 1'b1, adr, $urandom, 1'b0);
        7:          xact(sel, 1'(($urandom_range(0, 1))), 1'b1, adr | 32'($urandom_range(1, 3)),
                         $urandom, 1'b0);
        8:          xact(sel, 1'(($urandom_range(0, 1))), 1'b1,
                         32'($urandom_range(DEPTH, 32'h3FFF_FFFF)) << 2, $urandom, 1'b0);
        default:    xact(sel, 1'b1, 1'b1, adr, $urandom, 1'b0);
      endcase
    end
  endtask

  initial begin
    cmax_m[0] = (1 << CNTW_A) - 1;
    cmax_m[1] = (1 << CNTW_B) - 1;
    for (int s = 0; s < 2; s++) begin
      cnt_m[s] = 0;
      rd_m[s]  = 32'd0;
      for (int i = 0; i < DEPTH; i++) mem_m[s][i] = 32'd0;
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(get_ready(s)), 32'd0);
      chk("rst_err", 32'(get_err(s)), 32'd0);
      chk("rst_readdata", get_rdata(s), 32'd0);
      chk("rst_wr_count", get_cnt(s), 32'd0);
    end
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // ---------------- instance A, WAIT=2 ----------------
    xact(0, 1'b1, 1'b0, 32'd84, 32'd7, 1'b0);
    xact(0, 1'b0, 1'b1, 32'd84, 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("readdata_hold", a_readdata, 32'd7);

    xact(0, 1'b1, 1'b0, 32'd0, 32'h0BAD_0000, 1'b0);
    xact(0, 1'b1, 1'b0, 32'd82, 32'h55, 1'b0);
    xact(0, 1'b1, 1'b0, 32'd256, 32'h66, 1'b0);
    xact(0, 1'b1, 1'b1, 32'd0, 32'h77, 1'b0);
    xact(0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);

    // Reset in the middle of a write.
    xact(0, 1'b1, 1'b0, 32'd20, 32'hAAAA_0001, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd20, 32'h1234);
    @(posedge clk); #1;
    chk("midrst_ready_e", 32'(a_ready), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    cnt_m[0] = 0;
    rd_m[0]  = 32'd0;
    chk("midrst_wr_count", 32'(a_wr_count), 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_ready", 32'(a_ready), 32'd0);
    end
    chk("midrst_readdata", a_readdata, 32'd0);
    xact(0, 1'b0, 1'b1, 32'd20, 32'd0, 1'b0);
    chk("midrst_old_value", a_readdata, 32'hAAAA_0001);

    preload(0);
    random_run(0, 60);

    // ---------------- instance B, WAIT=0, CNT_W=2 ----------------
    for (int i = 0; i < 5; i++) begin
      xact(1, 1'b1, 1'b0, 32'(i) << 2, 32'(i + 100), 1'b0);
    end
    chk("sat_wr_count", 32'(b_wr_count), 32'd3);

    xact(1, 1'b1, 1'b0, 32'd16, 32'hFFFF_FFFA, 1'b0);
    xact(1, 1'b0, 1'b1, 32'd16, 32'd0, 1'b1);
    // The read is still held: the edge after the ready cycle takes it as a
    // new request, so a second ready follows one edge later.
    @(posedge clk); #1;
    chk("b2b_gap", 32'(b_ready), 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk("b2b_ready", 32'(b_ready), 32'd1);
    chk("b2b_err", 32'(b_err), 32'd0);
    chk("b2b_readdata", b_readdata, 32'hFFFF_FFFA);
    @(posedge clk); #1;
    chk("b2b_pulse", 32'(b_ready), 32'd0);

    preload(1);
    random_run(1, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
